// File: rtl/f2i_pkg.sv
// Shared types and constants for the iterative binary64 -> int64 converter.
// The classifier and the FSM/datapath both import this package.
package f2i_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

  localparam int EXP_W  = 11;
  localparam int MANT_W = 52;
  localparam int BIAS64 = 1023;

  localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  localparam int FLAG_INEXACT  = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INVALID  = 2;

  // Decoded operand: special results carry the final value in sig and skip shifting.
  typedef struct packed {
    logic        special;
    logic        sign;
    logic        left;
    logic [6:0]  n;
    logic [63:0] sig;
    logic [2:0]  flags;
  } f2i_class_t;

endpackage

// File: rtl/f2i_classify.sv
// Combinational field decode and range classification of a binary64 operand:
// special/preset result and flags, or shift count and direction for 0 <= u <= 62.
module f2i_classify
  import f2i_pkg::*;
(
  input  logic [63:0] in_data,
  output f2i_class_t  cls
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_U0  = EXP_W'(BIAS64);
  localparam logic [EXP_W-1:0] EXP_U52 = EXP_W'(BIAS64 + 52);
  localparam logic [EXP_W-1:0] EXP_U63 = EXP_W'(BIAS64 + 63);

  logic              sign;
  logic [EXP_W-1:0]  expo;
  logic [MANT_W-1:0] mant;

  assign sign = in_data[63];
  assign expo = in_data[62:52];
  assign mant = in_data[51:0];

  always_comb begin
    cls      = '0;
    cls.sign = sign;
    cls.sig  = {11'b0, 1'b1, mant};
    if (expo == EXP_MAX) begin
      cls.special = 1'b1;
      if (mant != '0) begin
        cls.sig                 = INT64_MIN;
        cls.flags[FLAG_INVALID] = 1'b1;
      end else begin
        cls.sig                  = sign ? INT64_MIN : INT64_MAX;
        cls.flags[FLAG_OVERFLOW] = 1'b1;
      end
    end else if (expo < EXP_U0) begin
      cls.special             = 1'b1;
      cls.sig                 = '0;
      cls.flags[FLAG_INEXACT] = (expo != '0) || (mant != '0);
    end else if (expo >= EXP_U63) begin
      cls.special = 1'b1;
      // -2^63 is the one value of magnitude >= 2^63 that is representable.
      if (sign && expo == EXP_U63 && mant == '0) begin
        cls.sig = INT64_MIN;
      end else begin
        cls.sig                  = sign ? INT64_MIN : INT64_MAX;
        cls.flags[FLAG_OVERFLOW] = 1'b1;
      end
    end else if (expo >= EXP_U52) begin
      cls.left = 1'b1;
      cls.n    = 7'(expo - EXP_U52);
    end else begin
      cls.n    = 7'(EXP_U52 - expo);
    end
  end

endmodule

// File: rtl/float2int64_iter.sv
// Iterative binary64 -> signed int64 conversion with truncation. The significand
// is shifted at most STEP bits per cycle, then negated, then held until taken.
module float2int64_iter
  import f2i_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [2:0]  out_flags
);

  localparam logic [6:0]  STEP_C   = 7'(STEP);
  localparam logic [63:0] ALL_ONES = '1;

  f2i_class_t cls;

  f2i_classify u_classify (
    .in_data (in_data),
    .cls     (cls)
  );

  state_t      state_reg, state_next;
  logic [63:0] sig_reg;
  logic [6:0]  cnt_reg;
  logic        sticky_reg;
  logic        left_reg;
  logic        sign_reg;
  logic        special_reg;
  logic [2:0]  preset_flags_reg;
  logic [63:0] out_data_reg;
  logic [2:0]  out_flags_reg;

  logic [6:0]  amt;
  logic [63:0] shifted;
  logic        lost;

  assign amt     = (cnt_reg > STEP_C) ? STEP_C : cnt_reg;
  assign shifted = left_reg ? (sig_reg << amt) : (sig_reg >> amt);
  assign lost    = |(sig_reg & ~(ALL_ONES << amt));

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_data_reg;
  assign out_flags = out_flags_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = cls.special ? NEG : SHIFT;
      SHIFT:   if (cnt_reg <= STEP_C) state_next = NEG;
      NEG:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg          <= '0;
      cnt_reg          <= '0;
      sticky_reg       <= 1'b0;
      left_reg         <= 1'b0;
      sign_reg         <= 1'b0;
      special_reg      <= 1'b0;
      preset_flags_reg <= '0;
      out_data_reg     <= '0;
      out_flags_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sig_reg          <= cls.sig;
            cnt_reg          <= cls.n;
            sticky_reg       <= 1'b0;
            left_reg         <= cls.left;
            sign_reg         <= cls.sign;
            special_reg      <= cls.special;
            preset_flags_reg <= cls.flags;
          end
        end
        SHIFT: begin
          sig_reg <= shifted;
          cnt_reg <= cnt_reg - amt;
          // Only right shifts can drop set bits; left shifts move zeros in.
          if (!left_reg) sticky_reg <= sticky_reg | lost;
        end
        NEG: begin
          out_data_reg  <= (sign_reg && !special_reg) ? -sig_reg : sig_reg;
          out_flags_reg <= preset_flags_reg | {2'b00, sticky_reg};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float2int64_iter.sv
// Self-checking bench for float2int64_iter: directed table, output hold,
// mid-operation reset, and randomized operands against an arithmetic model.
module tb_float2int64_iter;

  localparam int TB_STEP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  out_flags;

  int total = 0;
  int passed = 0;

  float2int64_iter #(.STEP(TB_STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp_data;
    logic [2:0]  exp_flags;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: value = {1,mant} * 2^(u-52), truncated toward zero, then signed.
  task automatic ref_model(input logic [63:0] x, output logic [63:0] r,
                           output logic [2:0] f, output int lat);
    logic s;
    int e, u, n;
    longint unsigned m, sig, mag, dv;
    s = x[63];
    e = int'(x[62:52]);
    m = longint'(x[51:0]);
    u = e - 1023;
    f = 3'b000;
    lat = 1;
    if (e == 2047) begin
      if (m != 0) begin r = 64'h8000_0000_0000_0000; f = 3'b100; end
      else begin r = s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF; f = 3'b010; end
    end else if (u < 0) begin
      r = '0;
      f = (e != 0 || m != 0) ? 3'b001 : 3'b000;
    end else if (u >= 63) begin
      if (s && u == 63 && m == 0) r = 64'h8000_0000_0000_0000;
      else begin r = s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF; f = 3'b010; end
    end else begin
      sig = m + (64'd1 << 52);
      if (u >= 52) begin
        n = u - 52;
        mag = sig * (64'd1 << n);
      end else begin
        n = 52 - u;
        dv = 64'd1 << n;
        mag = sig / dv;
        if (sig % dv != 0) f = 3'b001;
      end
      r = s ? (64'd0 - mag) : mag;
      lat = ((n == 0) ? 1 : (n + TB_STEP - 1) / TB_STEP) + 1;
    end
  endtask

  // Present an operand, then wait for out_valid while driving junk inputs.
  task automatic start_op(input logic [63:0] d, output logic [63:0] got_d,
                          output logic [2:0] got_f, output int lat);
    int guard;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_data = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    got_d = out_data;
    got_f = out_flags;
  endtask

  task automatic finish_op(input int hold, input logic [63:0] exp_d, input logic [2:0] exp_f);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_data", out_data, exp_d);
      check("hold_flags", 64'(out_flags), 64'(exp_f));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_take", 64'(in_ready), 64'd1);
  endtask

  task automatic run_checked(input string tag, input logic [63:0] d, input logic [63:0] exp_d,
                             input logic [2:0] exp_f, input int exp_lat, input int hold);
    logic [63:0] got_d;
    logic [2:0]  got_f;
    int          lat;
    start_op(d, got_d, got_f, lat);
    $display("%s op %h -> data %h flags %b lat %0d", tag, d, got_d, got_f, lat);
    check({tag, "_data"}, got_d, exp_d);
    check({tag, "_flags"}, 64'(got_f), 64'(exp_f));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    finish_op(hold, exp_d, exp_f);
  endtask

  initial begin
    vec_t vecs[$];
    logic [63:0] r, x;
    logic [2:0]  f;
    int          lat, bad;

    vecs.push_back('{64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 3'b000, 8});
    vecs.push_back('{64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 3'b001, 8});
    vecs.push_back('{64'h43D0_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b000, 3});
    vecs.push_back('{64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000, 1});
    vecs.push_back('{64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1});
    vecs.push_back('{64'h7FF8_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b100, 1});
    vecs.push_back('{64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1});
    vecs.push_back('{64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010, 1});
    vecs.push_back('{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b000, 1});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b000, 1});
    vecs.push_back('{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 3'b001, 1});
    vecs.push_back('{64'h4330_0000_0000_0000, 64'h0010_0000_0000_0000, 3'b000, 2});
    vecs.push_back('{64'hBFF0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 8});
    vecs.push_back('{64'h3FF8_0000_0000_0000, 64'h0000_0000_0000_0001, 3'b001, 8});
    vecs.push_back('{64'hC3D0_0000_0000_0001, 64'hBFFF_FFFF_FFFF_FC00, 3'b000, 3});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    foreach (vecs[i]) run_checked("vec", vecs[i].din, vecs[i].exp_data, vecs[i].exp_flags, vecs[i].exp_lat, 0);

    // 0.5 with the consumer stalling for 5 cycles
    run_checked("hold", 64'h3FE0_0000_0000_0000, 64'd0, 3'b001, 1, 5);

    // Reset during SHIFT discards the operand
    @(negedge clk);
    in_data  = 64'h3FF0_0000_0000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("midrst_no_result", 64'(bad), 64'd0);
    run_checked("postrst", 64'h4008_0000_0000_0000, 64'd3, 3'b000, 8, 0);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) x[62:52] = 11'($urandom_range(1015, 1090));
      if ($urandom_range(0, 7) == 0) x[51:0] = '0;
      ref_model(x, r, f, lat);
      run_checked("rand", x, r, f, lat, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/float2int64_iter.md
FLOAT2INT64_ITER -- requirements
Module: float2int64_iter

Interface
REQ-001 SHALL have parameter STEP, default 8, giving the maximum significand shift in bits per cycle; legal range 1..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_data holds an operand.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port in_data  input  64  IEEE-754 binary64: sign [63], exponent [62:52], mantissa [51:0].
REQ-007 SHALL have port out_valid  output  1  out_data and out_flags are valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port out_data  output  64  two's-complement signed 64-bit integer result.
REQ-010 SHALL have port out_flags  output  3  flag bits: [0] inexact, [1] overflow, [2] invalid.

Function
REQ-011 SHALL convert with round-toward-zero (truncation); u = exponent - 1023; significand = {1, mantissa} for exponent != 0.
REQ-012 SHALL use the FSM states IDLE, SHIFT, NEG and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 SHALL accept an operand on the edge where in_valid && in_ready; the move is IDLE->SHIFT for finite in-range operands and IDLE->NEG for special operands.
REQ-014 SHALL treat these as special operands: NaN (exp=2047, mant!=0) -> 0x8000_0000_0000_0000 with invalid=1; +/-inf -> 0x7FFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0000 with overflow=1.
REQ-015 SHALL apply the same saturation as infinity for u >= 63, with overflow=1; the exception is exactly -2^63, which returns 0x8000_0000_0000_0000 with no flags.
REQ-016 SHALL return 0 for u < 0 (this includes zero and denormals), with inexact = (exponent != 0 || mantissa != 0); this case is special.
REQ-017 SHALL handle 0 <= u <= 62 as follows: shift count n = |u - 52|; left shift if u >= 52, else right shift.
REQ-018 SHALL shift by min(STEP, remaining) in SHIFT each cycle; inexact accumulates as the OR of all bits shifted out on the right.
REQ-019 SHALL occupy SHIFT for max(1, ceil(n/STEP)) cycles; when n = 0 the SHIFT cycle shifts nothing.
REQ-020 SHALL make the NEG state last one cycle; it two's-complements the magnitude when sign = 1 (suppressed for special results), then the FSM moves to DONE.
REQ-021 SHALL raise out_valid at edge N after the accepting edge: N = max(1, ceil(n/STEP)) + 1 for shifted operands, and N = 1 for special operands.
REQ-022 SHALL hold out_data and out_flags stable while out_valid && !out_ready.
REQ-023 SHALL move DONE->IDLE on out_valid && out_ready; there is no accept in the same cycle, so the minimum spacing is N+2 cycles per operand.
REQ-024 SHALL ignore in_data and in_valid in every state except IDLE.
REQ-025 SHALL have a 64-bit significand datapath register, a 7-bit remaining-shift counter, and a sticky inexact bit.

Reset
REQ-026 SHALL, while rst_n is low, immediately force: state=IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_flags=0, counter=0.
REQ-027 SHALL discard any in-flight operand when reset is asserted mid-operation; no result is produced for it.

Structure
REQ-028 SHALL place the following in shared package f2i_pkg: state enum; BIAS64=1023; INT64_MAX and INT64_MIN; flag index constants; exponent and mantissa field widths.
REQ-029 SHALL implement field decode and special/range classification (class, u, n, direction, preset result and flags) in one combinational sub-module, f2i_classify.
REQ-030 SHALL keep the FSM and datapath in float2int64_iter.

Verification
REQ-031 SHALL cover: 0x3FF0_0000_0000_0000 (1.0), STEP=8 -> out_data=1, flags=000, out_valid at edge 8 after accept.
REQ-032 SHALL cover: 0xC004_0000_0000_0000 (-2.5) -> out_data=0xFFFF_FFFF_FFFF_FFFE, flags=001.
REQ-033 SHALL cover: 0x43D0_0000_0000_0000 (2^62) -> 0x4000_0000_0000_0000, flags=000, N=3; 0xC3E0_0000_0000_0000 -> 0x8000_0000_0000_0000, flags=000.
REQ-034 SHALL cover: 0x43E0_0000_0000_0000 (2^63) -> 0x7FFF_FFFF_FFFF_FFFF, flags=010; 0x7FF8_0000_0000_0000 (NaN) -> 0x8000_0000_0000_0000, flags=100, N=1.
REQ-035 SHALL cover: 0x3FE0_0000_0000_0000 (0.5) -> 0 with flags=001; out_ready held low 5 cycles -> out_data stable and in_ready=0 throughout.
REQ-036 SHALL cover: rst_n pulsed low during SHIFT -> out_valid stays 0, in_ready=1 after release, the next operand converts correctly.
